// File: rtl/mia_mat_pkg.sv
// Shared types and helpers for the row-organised complex matrix store.
// Element packing is {imag, real}; a row holds SIZE elements, element 0 lowest.
package mia_mat_pkg;

    localparam int WIDTH = 64;
    localparam int SIZE  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] im;
        logic [WIDTH-1:0] re;
    } cplx_t;

    typedef cplx_t [SIZE-1:0] row_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Column bus word 2i is real(row i), word 2i+1 is imag(row i).
    function automatic cplx_t col_to_elem(input logic [2*SIZE*WIDTH-1:0] col,
                                          input int i);
        cplx_t e;
        e.re = col[2*i*WIDTH +: WIDTH];
        e.im = col[(2*i+1)*WIDTH +: WIDTH];
        return e;
    endfunction

    function automatic cplx_t row_elem(input row_t row, input int j);
        return row[j];
    endfunction

endpackage

// File: rtl/mat_row_store_ctrl.sv
// IDLE/CLEAR sequencer, clear row counter, column bitmap and done pulses.
// Ports: clk_i, rst_ni, flush_i, clear_i, col_we_i/col_addr_i in; idle_o, busy_o, clear_we_o, clear_row_o, col_done_o, clear_done_o out.
module mat_row_store_ctrl #(
    parameter int SIZE = 4,
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          clear_i,
    input  logic          col_we_i,
    input  logic [AW-1:0] col_addr_i,
    output logic          idle_o,
    output logic          busy_o,
    output logic          clear_we_o,
    output logic [AW-1:0] clear_row_o,
    output logic          col_done_o,
    output logic          clear_done_o
);
    import mia_mat_pkg::*;

    logic [0:0]      state;
    logic [AW-1:0]   cnt;
    logic [SIZE-1:0] bitmap;
    logic [SIZE-1:0] col_bit;
    logic [SIZE-1:0] bitmap_nxt;

    always_comb begin
        col_bit = '0;
        if (col_we_i) col_bit[col_addr_i] = 1'b1;
        bitmap_nxt = bitmap | col_bit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bitmap       <= '0;
            col_done_o   <= 1'b0;
            clear_done_o <= 1'b0;
        end else begin
            col_done_o   <= 1'b0;
            clear_done_o <= 1'b0;
            if (flush_i) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                bitmap <= '0;
            end else begin
                unique case (1'b1)
                    (state == ST_IDLE): begin
                        if (clear_i) begin
                            state <= ST_CLEAR;
                            cnt   <= '0;
                        end
                        // Completion drops the bitmap so a rewrite cannot re-pulse.
                        if (&bitmap_nxt) begin
                            bitmap     <= '0;
                            col_done_o <= 1'b1;
                        end else begin
                            bitmap <= bitmap_nxt;
                        end
                    end
                    (state == ST_CLEAR): begin
                        if (cnt == AW'(SIZE - 1)) begin
                            state        <= ST_IDLE;
                            cnt          <= '0;
                            bitmap       <= '0;
                            clear_done_o <= 1'b1;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_o      = (state == ST_CLEAR);
    assign idle_o      = (state == ST_IDLE);
    assign clear_we_o  = busy_o;
    assign clear_row_o = cnt;

endmodule

// File: rtl/mat_row_store.sv
// Complex matrix row store: registered row reads, row writes, transposed column writes, sequenced clear.
// Ports: read req/resp (rd_*), row write (wr_*), column write (col_*), flush_i/clear_i control, status pulses and busy_o.
module mat_row_store #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 64,
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int EW = 2 * WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    clear_i,
    input  logic [AW-1:0]           rd_addr_i,
    input  logic                    rd_addr_valid_i,
    output logic                    rd_ready_o,
    output logic [SIZE*EW-1:0]      rd_row_o,
    output logic [AW-1:0]           rd_addr_o,
    output logic                    rd_row_valid_o,
    input  logic [SIZE*EW-1:0]      wr_row_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic                    wr_valid_i,
    input  logic [2*SIZE*WIDTH-1:0] col_i,
    input  logic [AW-1:0]           col_addr_i,
    input  logic                    col_valid_i,
    output logic                    wr_ready_o,
    output logic                    col_done_o,
    output logic                    clear_done_o,
    output logic                    busy_o
);
    import mia_mat_pkg::*;

    logic          idle;
    logic          clear_we;
    logic [AW-1:0] clear_row;
    logic          rd_ok;
    logic          wr_ok;
    logic          col_ok;
    logic          rd_acc;
    logic          row_we;
    logic          col_we;
    logic          zero_we;

    logic [EW-1:0]      mem [SIZE][SIZE];
    logic [SIZE*EW-1:0] rd_mux;

    generate
        if ((1 << AW) == SIZE) begin : g_pow2
            assign rd_ok  = 1'b1;
            assign wr_ok  = 1'b1;
            assign col_ok = 1'b1;
        end else begin : g_npow2
            assign rd_ok  = (rd_addr_i < AW'(SIZE));
            assign wr_ok  = (wr_addr_i < AW'(SIZE));
            assign col_ok = (col_addr_i < AW'(SIZE));
        end
    endgenerate

    assign rd_ready_o = idle & ~flush_i;
    assign wr_ready_o = idle & ~flush_i;
    assign rd_acc     = rd_addr_valid_i & rd_ready_o;
    assign row_we     = wr_valid_i & wr_ready_o & wr_ok;
    assign col_we     = col_valid_i & wr_ready_o & col_ok;
    assign zero_we    = clear_we & ~flush_i;

    mat_row_store_ctrl #(.SIZE(SIZE)) u_ctrl (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .clear_i      (clear_i),
        .col_we_i     (col_we),
        .col_addr_i   (col_addr_i),
        .idle_o       (idle),
        .busy_o       (busy_o),
        .clear_we_o   (clear_we),
        .clear_row_o  (clear_row),
        .col_done_o   (col_done_o),
        .clear_done_o (clear_done_o)
    );

    // Storage is deliberately unreset; the column assignment comes last so
    // it overrides a same-cycle row write at the intersection.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                if (zero_we && clear_row == AW'(i)) begin
                    mem[i][j] <= '0;
                end else begin
                    if (row_we && wr_addr_i == AW'(i))
                        mem[i][j] <= wr_row_i[j*EW +: EW];
                    if (col_we && col_addr_i == AW'(j))
                        mem[i][j] <= {col_i[(2*i+1)*WIDTH +: WIDTH],
                                      col_i[2*i*WIDTH +: WIDTH]};
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (rd_ok) begin
            for (int j = 0; j < SIZE; j++)
                rd_mux[j*EW +: EW] = mem[rd_addr_i][j];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_row_o       <= '0;
            rd_addr_o      <= '0;
            rd_row_valid_o <= 1'b0;
        end else begin
            rd_row_valid_o <= rd_acc;
            if (rd_acc) begin
                rd_row_o  <= rd_mux;
                rd_addr_o <= rd_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_mat_row_store.sv
// Directed self-checking bench for mat_row_store (SIZE=4, WIDTH=64 doubles).
// Drives inputs 1 time unit after each rising edge and checks registered outputs there.
module tb_mat_row_store;
    import mia_mat_pkg::*;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int RW = N * 2 * W;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            clear_i;
    logic [1:0]      rd_addr_i;
    logic            rd_addr_valid_i;
    logic            rd_ready_o;
    logic [RW-1:0]   rd_row_o;
    logic [1:0]      rd_addr_o;
    logic            rd_row_valid_o;
    logic [RW-1:0]   wr_row_i;
    logic [1:0]      wr_addr_i;
    logic            wr_valid_i;
    logic [RW-1:0]   col_i;
    logic [1:0]      col_addr_i;
    logic            col_valid_i;
    logic            wr_ready_o;
    logic            col_done_o;
    logic            clear_done_o;
    logic            busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    row_t exp_rows [N];
    row_t r;

    mat_row_store #(.SIZE(N), .WIDTH(W)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .clear_i         (clear_i),
        .rd_addr_i       (rd_addr_i),
        .rd_addr_valid_i (rd_addr_valid_i),
        .rd_ready_o      (rd_ready_o),
        .rd_row_o        (rd_row_o),
        .rd_addr_o       (rd_addr_o),
        .rd_row_valid_o  (rd_row_valid_o),
        .wr_row_i        (wr_row_i),
        .wr_addr_i       (wr_addr_i),
        .wr_valid_i      (wr_valid_i),
        .col_i           (col_i),
        .col_addr_i      (col_addr_i),
        .col_valid_i     (col_valid_i),
        .wr_ready_o      (wr_ready_o),
        .col_done_o      (col_done_o),
        .clear_done_o    (clear_done_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [RW-1:0] obs,
                       input logic [RW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cplx_t mk(input real re, input real im);
        cplx_t e;
        e.re = $realtobits(re);
        e.im = $realtobits(im);
        return e;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_ready"}, RW'(rd_ready_o), RW'(1));
        chk({tag, "_wr_ready"}, RW'(wr_ready_o), RW'(1));
        chk({tag, "_busy"}, RW'(busy_o), RW'(0));
        chk({tag, "_rvalid"}, RW'(rd_row_valid_o), RW'(0));
        chk({tag, "_row"}, rd_row_o, RW'(0));
        chk({tag, "_addr"}, RW'(rd_addr_o), RW'(0));
        chk({tag, "_coldone"}, RW'(col_done_o), RW'(0));
        chk({tag, "_clrdone"}, RW'(clear_done_o), RW'(0));
    endtask

    task automatic read_row(input int a, input string tag,
                            input logic [RW-1:0] exp);
        rd_addr_i       = 2'(a);
        rd_addr_valid_i = 1'b1;
        tick();
        rd_addr_valid_i = 1'b0;
        chk({tag, "_valid"}, RW'(rd_row_valid_o), RW'(1));
        chk({tag, "_addr"}, RW'(rd_addr_o), RW'(a));
        chk({tag, "_data"}, rd_row_o, exp);
    endtask

    task automatic load_col(input int c, input int base);
        col_i = '0;
        for (int i = 0; i < N; i++) begin
            col_i[2*i*W +: W]     = $realtobits(real'(base*i + c));
            col_i[(2*i+1)*W +: W] = $realtobits(-real'(base*i + c));
        end
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; clear_i = 1'b0;
        rd_addr_i = '0; rd_addr_valid_i = 1'b0;
        wr_row_i = '0; wr_addr_i = '0; wr_valid_i = 1'b0;
        col_i = '0; col_addr_i = '0; col_valid_i = 1'b0;
        #3;
        chk_reset_vals("rst");
        #5 rst_ni = 1'b1;
        tick();

        // Clear: 4 busy cycles, done pulse, reads ignored while busy.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_busy0", RW'(busy_o), RW'(1));
        chk("clr_rdy0", RW'(rd_ready_o), RW'(0));
        chk("clr_wrdy0", RW'(wr_ready_o), RW'(0));
        rd_addr_i = 2'd0; rd_addr_valid_i = 1'b1;
        tick();
        rd_addr_valid_i = 1'b0;
        chk("clr_rd_ignored", RW'(rd_row_valid_o), RW'(0));
        chk("clr_busy1", RW'(busy_o), RW'(1));
        tick();
        chk("clr_busy2", RW'(busy_o), RW'(1));
        tick();
        chk("clr_busy3", RW'(busy_o), RW'(1));
        chk("clr_nodone3", RW'(clear_done_o), RW'(0));
        tick();
        chk("clr_busy4", RW'(busy_o), RW'(0));
        chk("clr_done", RW'(clear_done_o), RW'(1));
        chk("clr_rdy_back", RW'(rd_ready_o), RW'(1));
        for (int a = 0; a < N; a++) begin
            read_row(a, $sformatf("zero_r%0d", a), '0);
            if (a == 0) chk("clr_done_1cyc", RW'(clear_done_o), RW'(0));
        end
        tick();
        chk("idle_rvalid0", RW'(rd_row_valid_o), RW'(0));

        // Row write to row 2 while reading row 2: read-before-write.
        for (int j = 0; j < N; j++) r[j] = mk(real'(j), real'(j) + 0.5);
        exp_rows[2] = r;
        wr_row_i = r; wr_addr_i = 2'd2; wr_valid_i = 1'b1;
        rd_addr_i = 2'd2; rd_addr_valid_i = 1'b1;
        tick();
        wr_valid_i = 1'b0; rd_addr_valid_i = 1'b0;
        chk("rbw_old", rd_row_o, '0);
        chk("rbw_valid", RW'(rd_row_valid_o), RW'(1));
        read_row(2, "rowwr", exp_rows[2]);
        chk("rowwr_elem3_im", RW'(row_elem(exp_rows[2], 3).im),
            RW'($realtobits(3.5)));

        // Four column writes: transposed, single done pulse.
        for (int c = 0; c < N; c++) begin
            load_col(c, 10);
            col_addr_i = 2'(c); col_valid_i = 1'b1;
            for (int i = 0; i < N; i++)
                exp_rows[i][c] = col_to_elem(col_i, i);
            tick();
            chk($sformatf("coldone_c%0d", c), RW'(col_done_o),
                RW'(c == N - 1));
        end
        col_valid_i = 1'b0;
        tick();
        chk("coldone_once", RW'(col_done_o), RW'(0));
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++)
                r[c] = mk(real'(10*i + c), -real'(10*i + c));
            chk($sformatf("col_model_r%0d", i), exp_rows[i], r);
            read_row(i, $sformatf("colrd_r%0d", i), r);
        end

        // Same-cycle row write (row 1) and column write (col 3).
        for (int j = 0; j < N; j++) r[j] = mk(7.0, 7.0);
        wr_row_i = r; wr_addr_i = 2'd1; wr_valid_i = 1'b1;
        col_i = '0;
        for (int i = 0; i < N; i++) begin
            col_i[2*i*W +: W]     = $realtobits(i == 1 ? 2.0 : 100.0 + i);
            col_i[(2*i+1)*W +: W] = $realtobits(i == 1 ? -2.0 : -(100.0 + i));
        end
        col_addr_i = 2'd3; col_valid_i = 1'b1;
        tick();
        wr_valid_i = 1'b0; col_valid_i = 1'b0;
        chk("overlay_nodone", RW'(col_done_o), RW'(0));
        r[3] = mk(2.0, -2.0);
        read_row(1, "overlay_r1", r);
        for (int c = 0; c < 3; c++) r[c] = mk(real'(30 + c), -real'(30 + c));
        r[3] = mk(103.0, -103.0);
        exp_rows[3] = r;
        read_row(3, "overlay_r3", exp_rows[3]);

        // Flush on the second CLEAR cycle.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("fl_busy0", RW'(busy_o), RW'(1));
        tick();
        chk("fl_busy1", RW'(busy_o), RW'(1));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_busy_drop", RW'(busy_o), RW'(0));
        chk("fl_nodone0", RW'(clear_done_o), RW'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("fl_nodone%0d", k + 1), RW'(clear_done_o), RW'(0));
        end
        read_row(0, "fl_r0_zero", '0);
        read_row(3, "fl_r3_kept", exp_rows[3]);

        // Flush drops a same-cycle read and row write.
        for (int j = 0; j < N; j++) r[j] = mk(55.0, 55.0);
        wr_row_i = r; wr_addr_i = 2'd0; wr_valid_i = 1'b1;
        rd_addr_i = 2'd3; rd_addr_valid_i = 1'b1; flush_i = 1'b1;
        tick();
        wr_valid_i = 1'b0; rd_addr_valid_i = 1'b0; flush_i = 1'b0;
        chk("fl_rd_dropped", RW'(rd_row_valid_o), RW'(0));
        read_row(0, "fl_wr_dropped", '0);

        // Asynchronous reset in the middle of CLEAR.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
        chk("ar_busy", RW'(busy_o), RW'(1));
        #2 rst_ni = 1'b0;
        #1;
        chk_reset_vals("ar");
        #2 rst_ni = 1'b1;
        tick();
        chk("ar_wr_ready", RW'(wr_ready_o), RW'(1));
        chk("ar_idle", RW'(busy_o), RW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
